// File: rtl/mp_regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// NRD combinational read ports with same-cycle write bypass, NWR synchronous
// write ports (highest index wins on conflict), NWR allocate ports that mark
// destinations busy, and a registered popcount of the busy vector.
module mp_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 4,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    input  logic [NWR-1:0]          alloc_en,
    input  logic [NWR*ADDR_W-1:0]   alloc_addr,
    output logic [ADDR_W:0]         busy_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Number of set bits in a busy vector; bounded by DEPTH so ADDR_W+1 bits suffice.
    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, vec[k]};
        end
        return cnt;
    endfunction

    // True when the address is the hardwired zero register.
    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_next_s;
    logic [NWR-1:0]    wr_valid_s;
    logic [NWR-1:0]    alloc_valid_s;

    // Qualify write and allocate ports: anything aimed at the zero register is dropped.
    always_comb begin
        wr_valid_s    = {NWR{1'b0}};
        alloc_valid_s = {NWR{1'b0}};
        for (int j = 0; j < NWR; j++) begin
            wr_valid_s[j]    = wr_en[j]    && !is_zero_addr(wr_addr[j*ADDR_W +: ADDR_W]);
            alloc_valid_s[j] = alloc_en[j] && !is_zero_addr(alloc_addr[j*ADDR_W +: ADDR_W]);
        end
    end

    // Read ports: array contents, overridden by the highest-index matching write this cycle.
    always_comb begin
        rd_data = {(NRD*DATA_W){1'b0}};
        rd_busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            logic              hit;
            a   = rd_addr[i*ADDR_W +: ADDR_W];
            d   = mem_r[a];
            hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_valid_s[j] && (wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
                    d   = wr_data[j*DATA_W +: DATA_W];
                    hit = 1'b1;
                end else begin
                    d   = d;
                    hit = hit;
                end
            end
            if (is_zero_addr(a)) begin
                rd_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy[i]                  = 1'b0;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = d;
                rd_busy[i]                  = busy_r[a] && !hit;
            end
        end
    end

    // Busy next state: writeback clears, then allocate sets so a new producer wins.
    always_comb begin
        busy_next_s = busy_r;
        for (int j = 0; j < NWR; j++) begin
            if (wr_valid_s[j]) begin
                busy_next_s[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end else begin
                busy_next_s = busy_next_s;
            end
        end
        for (int j = 0; j < NWR; j++) begin
            if (alloc_valid_s[j]) begin
                busy_next_s[alloc_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end else begin
                busy_next_s = busy_next_s;
            end
        end
    end

    // Register array: clear on reset, otherwise apply writes in port order so the top port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_r[r] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_valid_s[j]) begin
                    mem_r[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_count <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r     <= busy_next_s;
            busy_count <= popcount(busy_next_s);
        end
    end

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Directed self-checking bench for mp_regfile_sb with default parameters.
module tb_mp_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 4;
    localparam int NWR    = 2;

    logic                  clk;
    logic                  rst;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*ADDR_W-1:0] wr_addr;
    logic [NWR*DATA_W-1:0] wr_data;
    logic [NWR-1:0]        alloc_en;
    logic [NWR*ADDR_W-1:0] alloc_addr;
    logic [ADDR_W:0]       busy_count;

    int checks;
    int errors;

    mp_regfile_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        wr_en    = '0;
        alloc_en = '0;
    endtask

    task automatic set_wr(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en[p]                    = 1'b1;
        wr_addr[p*ADDR_W +: ADDR_W] = a;
        wr_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_alloc(input int p, input logic [ADDR_W-1:0] a);
        alloc_en[p]                    = 1'b1;
        alloc_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        rd_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic chk_data(input string name, input int p, input logic [DATA_W-1:0] exp);
        logic [DATA_W-1:0] got;
        #1;
        got = rd_data[p*DATA_W +: DATA_W];
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: rd_data[%0d] got %h expected %h", name, p, got, exp);
        end
    endtask

    task automatic chk_busy(input string name, input int p, input logic exp);
        #1;
        checks++;
        if (rd_busy[p] !== exp) begin
            errors++;
            $display("FAIL %s: rd_busy[%0d] got %b expected %b", name, p, rd_busy[p], exp);
        end
    endtask

    task automatic chk_count(input string name, input logic [ADDR_W:0] exp);
        checks++;
        if (busy_count !== exp) begin
            errors++;
            $display("FAIL %s: busy_count got %0d expected %0d", name, busy_count, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ctl();
        step();
        step();
        rst = 1'b0;
        chk_count("reset_count", 6'd0);
        set_rd(0, 5'd5);
        chk_data("reset_data", 0, 32'h0);
        chk_busy("reset_busy", 0, 1'b0);
    endtask

    task automatic test_write();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        step();
        clear_ctl();
        set_rd(0, 5'd5);
        chk_data("write_r5", 0, 32'hDEADBEEF);
        chk_busy("write_r5_busy", 0, 1'b0);
        chk_count("write_count", 6'd0);
    endtask

    task automatic test_bypass();
        set_rd(1, 5'd7);
        chk_data("bypass_pre", 1, 32'h0);
        set_wr(0, 5'd7, 32'h11);
        chk_data("bypass_same_cycle", 1, 32'h11);
        step();
        clear_ctl();
        chk_data("bypass_after", 1, 32'h11);
    endtask

    task automatic test_conflict();
        set_rd(2, 5'd3);
        set_wr(0, 5'd3, 32'hAA);
        set_wr(1, 5'd3, 32'hBB);
        chk_data("conflict_same_cycle", 2, 32'hBB);
        step();
        clear_ctl();
        chk_data("conflict_after", 2, 32'hBB);
    endtask

    task automatic test_multi_read();
        set_wr(1, 5'd10, 32'h1234_5678);
        step();
        clear_ctl();
        for (int p = 0; p < NRD; p++) set_rd(p, 5'd10);
        for (int p = 0; p < NRD; p++) chk_data("multi_read", p, 32'h1234_5678);
    endtask

    task automatic test_scoreboard();
        set_rd(0, 5'd4);
        set_rd(1, 5'd9);
        set_alloc(0, 5'd4);
        set_alloc(1, 5'd9);
        chk_busy("alloc_not_visible_r4", 0, 1'b0);
        chk_busy("alloc_not_visible_r9", 1, 1'b0);
        step();
        clear_ctl();
        chk_busy("alloc_r4", 0, 1'b1);
        chk_busy("alloc_r9", 1, 1'b1);
        chk_count("alloc_count", 6'd2);
        // writeback clears r4, visible on rd_busy in the same cycle
        set_wr(0, 5'd4, 32'h5);
        chk_busy("wb_bypass_busy_r4", 0, 1'b0);
        chk_data("wb_bypass_data_r4", 0, 32'h5);
        chk_busy("wb_other_r9", 1, 1'b1);
        step();
        clear_ctl();
        chk_count("wb_count", 6'd1);
        chk_busy("wb_after_r4", 0, 1'b0);
        // allocate beats clear on r9
        set_alloc(0, 5'd9);
        set_wr(0, 5'd9, 32'h66);
        step();
        clear_ctl();
        chk_busy("alloc_beats_clear_r9", 1, 1'b1);
        chk_data("alloc_beats_clear_data", 1, 32'h66);
        chk_count("alloc_beats_clear_count", 6'd1);
        // duplicate allocate onto an already-busy register
        set_alloc(0, 5'd9);
        set_alloc(1, 5'd9);
        step();
        clear_ctl();
        chk_count("dup_alloc_busy", 6'd1);
        // duplicate allocate onto a fresh register counts once
        set_alloc(0, 5'd12);
        set_alloc(1, 5'd12);
        step();
        clear_ctl();
        chk_count("dup_alloc_fresh", 6'd2);
        set_wr(1, 5'd12, 32'h1);
        step();
        clear_ctl();
        chk_count("clear_r12", 6'd1);
    endtask

    task automatic test_zero_reg();
        set_rd(3, 5'd0);
        set_wr(0, 5'd0, 32'hFFFF);
        set_alloc(0, 5'd0);
        chk_data("zero_bypass_data", 3, 32'h0);
        chk_busy("zero_bypass_busy", 3, 1'b0);
        step();
        clear_ctl();
        chk_data("zero_after_data", 3, 32'h0);
        chk_busy("zero_after_busy", 3, 1'b0);
        chk_count("zero_count", 6'd1);
    endtask

    task automatic test_reset_mid();
        set_wr(0, 5'd2, 32'h77);
        set_alloc(0, 5'd2);
        step();
        clear_ctl();
        set_rd(0, 5'd2);
        set_rd(1, 5'd9);
        chk_data("mid_pre_data_r2", 0, 32'h77);
        chk_busy("mid_pre_busy_r2", 0, 1'b1);
        chk_count("mid_pre_count", 6'd2);
        rst = 1'b1;
        set_wr(0, 5'd2, 32'h99);
        chk_data("mid_rst_bypass", 0, 32'h99);
        step();
        rst = 1'b0;
        clear_ctl();
        chk_data("mid_after_r2", 0, 32'h0);
        chk_busy("mid_after_busy_r2", 0, 1'b0);
        chk_data("mid_after_r9", 1, 32'h0);
        chk_busy("mid_after_busy_r9", 1, 1'b0);
        chk_count("mid_after_count", 6'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = '0;
        alloc_addr = '0;
        test_reset();
        test_write();
        test_bypass();
        test_conflict();
        test_multi_read();
        test_scoreboard();
        test_zero_reg();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_regfile_sb.md
Name: mp_regfile_sb

Overview:
- Parametrised multi-port register file for the superscalar core, with a per-register busy scoreboard.
- Provides NRD combinational read ports, each with same-cycle write bypass, and NWR synchronous write ports with fixed priority.
- Issue marks destination registers busy through NWR allocate ports; writeback clears them.
- Sits between decode/issue (read, allocate) and writeback (write, clear).

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, register address width; depth = 2**ADDR_W
NRD, 4, number of read ports
NWR, 2, number of write ports, also the number of allocate ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy; 0 = register 0 is ordinary

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
rd_addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  read data, combinational, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NRD  busy flag of the register addressed by port i, combinational
wr_en  in  NWR  write enables
wr_addr  in  NWR*ADDR_W  write addresses
wr_data  in  NWR*DATA_W  write data
alloc_en  in  NWR  allocate enables; set busy on the addressed register
alloc_addr  in  NWR*ADDR_W  allocate addresses
busy_count  out  ADDR_W+1  registered count of busy registers

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset, at the clk edge with rst=1:
  - all registers cleared to 0, all busy bits cleared, busy_count=0;
  - wr_en and alloc_en ignored in that cycle.
- Write:
  - at the clk edge, each port j with wr_en[j]=1 writes wr_data[j] to wr_addr[j];
  - if several ports target the same address, the highest port index wins.
- Zero register (ZERO_REG=1): writes and allocates to address 0 are dropped; reads of address 0 return 0 with busy=0, bypass included.
- Read, zero latency: rd_data[i] equals the winning same-cycle write data when some wr_en[j]=1 and wr_addr[j]=rd_addr[i] (valid address); otherwise it equals the array contents.
- Read during rst=1 follows the same rule: the array still holds pre-reset values until the edge.
- Busy next-state, per register r:
  - set if any valid alloc targets r;
  - else cleared if any valid write targets r;
  - else held.
  - Allocate beats clear on the same register in the same cycle: the new producer overrides the old one.
- Busy bypass: rd_busy[i] = busy[a] AND NOT(any valid wr_en to a), where a = rd_addr[i].
  - A same-cycle allocate does NOT appear on rd_busy until the next cycle.
- Allocate to an already-busy register: the bit stays 1 and the count is unchanged. Duplicate allocate ports on one address count once.
- Write to a non-busy register is legal: data is written and busy stays 0.
- busy_count:
  - registered; equals the popcount of the busy vector after the edge;
  - range 0..2**ADDR_W (0..2**ADDR_W-1 when ZERO_REG=1);
  - no overflow possible.
- All read ports are independent. Identical addresses on several read ports return identical data.

Test Plan:
- Reset, then write port0 r5=0xDEADBEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF, rd_busy0=0, busy_count=0.
- Bypass: in the same cycle wr_en0 r7=0x11 and rd_addr1=7 -> rd_data1=0x11 before the edge; after the edge the array holds 0x11.
- Write conflict: port0 r3=0xAA and port1 r3=0xBB in the same cycle -> rd_data on r3=0xBB both during the cycle and after the edge.
- Scoreboard:
  - alloc r4 and r9 -> next cycle rd_busy on r4 and r9 = 1, busy_count=2;
  - write r4=0x5 -> rd_busy on r4 drops in the same cycle; after the edge busy_count=1;
  - alloc r9 plus write r9 in one cycle -> r9 still busy, busy_count=1.
- ZERO_REG=1: write r0=0xFFFF plus alloc r0 -> rd_data=0, rd_busy=0, busy_count unchanged.
- Reset mid-operation: with r2 busy and r2=0x77, assert rst while wr_en0 r2=0x99 -> after the edge r2=0, busy_count=0, no write applied.
